// File: rtl/dmem_lsu.sv
// Load/store unit for a 4-column x 8-bit data memory port.
// Splits misaligned accesses into two word beats and returns extended load data.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// BEAT1 | first memory beat at the request's word address
// BEAT2 | second beat at word+1 for accesses crossing a word boundary
// RESP  | load result held on the response channel until accepted
module dmem_lsu #(
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_st,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  mem_valid_st,
  output logic                  mem_spec_ld,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    st_q, uns_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [31:0]             data_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [31:0]             result_q, result_d;
  logic [31:0]             resp_data_q, resp_data_d;
  logic [TAG_WIDTH-1:0]    resp_tag_q, resp_tag_d;

  logic [2:0]              nb, n1, n2;
  logic [1:0]              off;
  logic                    split;
  logic [ADDR_WIDTH-1:0]   word;
  logic [7:0]              we_wide;
  logic [31:0]             beat1_bytes, beat2_bytes, m2, assembled, ext_data;
  logic                    load_done;

  assign req_ready  = (state_q == IDLE);
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

  // Access geometry derived from the captured request.
  always_comb begin
    nb    = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
    off   = addr_q[1:0];
    word  = addr_q[ADDR_WIDTH+1:2];
    split = ({1'b0, off} + nb) > 3'd4;
    n1    = split ? (3'd4 - {1'b0, off}) : nb;
    n2    = {1'b0, off} + nb - 3'd4;
    we_wide = ((8'd1 << nb) - 8'd1) << off;
    for (int c = 0; c < 4; c++) begin
      m2[8*c +: 8] = (c < int'(n2)) ? 8'hFF : 8'h00;
    end
    // Beat 1 bytes land at the bottom of the result; beat 2 bytes stack above them.
    beat1_bytes = mem_dout >> {off, 3'b000};
    beat2_bytes = (mem_dout & m2) << {n1, 3'b000};
  end

  // Next-state, memory port drive and load assembly.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    mem_valid_st = 1'b0;
    mem_spec_ld  = 1'b0;
    mem_we       = 4'h0;
    mem_addr     = '0;
    mem_din      = 32'h0;
    resp_valid   = 1'b0;
    assembled    = result_q;
    load_done    = 1'b0;
    ext_data     = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = BEAT1;
      end
      BEAT1: begin
        mem_addr = word;
        if (st_q) begin
          mem_valid_st = 1'b1;
          mem_we       = we_wide[3:0];
          mem_din      = data_q << {off, 3'b000};
        end else begin
          mem_spec_ld = 1'b1;
          assembled   = beat1_bytes;
          result_d    = beat1_bytes;
        end
        if (split)     state_d = BEAT2;
        else if (st_q) state_d = IDLE;
        else begin
          state_d   = RESP;
          load_done = 1'b1;
        end
      end
      BEAT2: begin
        mem_addr = word + ADDR_WIDTH'(1);
        if (st_q) begin
          mem_valid_st = 1'b1;
          mem_we       = (4'd1 << n2) - 4'd1;
          mem_din      = data_q >> {n1, 3'b000};
          state_d      = IDLE;
        end else begin
          mem_spec_ld = 1'b1;
          assembled   = result_q | beat2_bytes;
          result_d    = assembled;
          state_d     = RESP;
          load_done   = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (nb)
      3'd1:    ext_data = uns_q ? {24'h0, assembled[7:0]}  : {{24{assembled[7]}}, assembled[7:0]};
      3'd2:    ext_data = uns_q ? {16'h0, assembled[15:0]} : {{16{assembled[15]}}, assembled[15:0]};
      default: ext_data = assembled;
    endcase
    if (load_done) begin
      resp_data_d = ext_data;
      resp_tag_d  = tag_q;
    end

    // A reset cycle must not issue a beat or present a response.
    if (reset) begin
      mem_valid_st = 1'b0;
      mem_spec_ld  = 1'b0;
      mem_we       = 4'h0;
      mem_addr     = '0;
      mem_din      = 32'h0;
      resp_valid   = 1'b0;
    end
  end

  // State, partial result and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= 32'h0;
      resp_data_q <= 32'h0;
      resp_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  // Request capture on handshake in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      data_q <= 32'h0;
      tag_q  <= '0;
    end else if (req_valid && req_ready) begin
      st_q   <= req_st;
      uns_q  <= req_unsigned;
      size_q <= req_size;
      addr_q <= req_addr;
      data_q <= req_data;
      tag_q  <= req_tag;
    end
  end

endmodule
